// File: rtl/agc_pkg.sv
// Shared constants for the Apollo CPU datapath: MCT sequencer states and timepulse layout.
// The decode FSM imports the same timing constants so both agree on strobe positions.
package agc_pkg;

  localparam int TP_PER_MCT = 12;
  localparam int MAX_MCT    = 6;
  localparam int MCT_W      = 3;
  localparam int TP_W       = 4;
  localparam int RD_TP      = 4;
  localparam int WR_TP      = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_RUPT = 2'd3
  } state_t;

  // A zero-length request still needs one MCT; oversize requests saturate.
  function automatic logic [MCT_W-1:0] clamp_len(input logic [MCT_W-1:0] len);
    if (len == '0) return MCT_W'(1);
    if (len > MCT_W'(MAX_MCT)) return MCT_W'(MAX_MCT);
    return len;
  endfunction

endpackage

// File: rtl/agc_tp_counter.sv
// Timepulse counter: wraps 1..TP_PER_MCT, 0 when cleared.
// Priority is clear, then load-1, then hold, then advance.
module agc_tp_counter
  import agc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_load1,
  input  logic            i_hold,
  output logic [TP_W-1:0] o_tp,
  output logic            o_wrap
);

  logic [TP_W-1:0] r_tp;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_tp <= '0;
    end else if (i_load1) begin
      r_tp <= TP_W'(1);
    end else if (!i_hold) begin
      r_tp <= (r_tp == TP_W'(TP_PER_MCT)) ? TP_W'(1) : r_tp + 1'b1;
    end
  end

  assign o_tp   = r_tp;
  assign o_wrap = (r_tp == TP_W'(TP_PER_MCT));

endmodule

// File: rtl/agc_mct_sequencer.sv
// MCT sequencer: steps T1..T12 per memory cycle, stretches on memory stall,
// tracks EXTEND and inserts a one-MCT interrupt entry between instructions.
module agc_mct_sequencer
  import agc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [MCT_W-1:0] i_mct_len,
  input  logic             i_extend_req,
  input  logic             i_stall,
  input  logic             i_int_pending,
  input  logic             i_int_inhibit,
  output logic [TP_W-1:0]  o_tp,
  output logic [MCT_W-1:0] o_mct,
  output logic             o_rd_en,
  output logic             o_wr_en,
  output logic             o_sub_done,
  output logic             o_busy,
  output logic             o_in_rupt,
  output logic             o_int_ack,
  output logic             o_extend_flag
);

  state_t           r_state;
  logic [MCT_W-1:0] r_mct;
  logic [MCT_W-1:0] r_len;
  logic             r_hold_rupt;
  logic             r_extend_flag;

  logic [TP_W-1:0]  w_tp;
  logic             w_wrap;
  logic             w_at_strobe;
  logic             w_last_mct;
  logic             w_rupt_ok;
  logic             w_start_acc;
  logic             w_stall_now;
  logic             w_going_idle;

  assign w_at_strobe = (w_tp == TP_W'(RD_TP)) || (w_tp == TP_W'(WR_TP));
  assign w_last_mct  = (r_mct == r_len);
  // The extend term uses the flag value being latched at this boundary, so an
  // EXTEND blocks interrupt entry only at its own boundary, not the next one.
  assign w_rupt_ok   = i_int_pending & ~i_int_inhibit & ~i_extend_req;
  assign w_start_acc = (r_state == S_IDLE) & i_start;
  assign w_stall_now = ((r_state == S_RUN) || (r_state == S_RUPT)) & w_at_strobe & i_stall;
  assign w_going_idle = w_wrap & (((r_state == S_RUN) & w_last_mct & ~w_rupt_ok) |
                                  (r_state == S_RUPT));

  agc_tp_counter u_tp (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_going_idle | ((r_state == S_IDLE) & ~i_start)),
    .i_load1 (w_start_acc),
    .i_hold  (w_stall_now | ((r_state == S_HOLD) & i_stall)),
    .o_tp    (w_tp),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mct         <= '0;
      r_len         <= '0;
      r_hold_rupt   <= 1'b0;
      r_extend_flag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_RUN;
            r_mct   <= MCT_W'(1);
            r_len   <= clamp_len(i_mct_len);
          end
        end
        S_RUN: begin
          if (w_stall_now) begin
            r_state     <= S_HOLD;
            r_hold_rupt <= 1'b0;
          end else if (w_wrap) begin
            if (!w_last_mct) begin
              r_mct <= r_mct + 1'b1;
            end else begin
              r_extend_flag <= i_extend_req;
              if (w_rupt_ok) begin
                r_state <= S_RUPT;
                r_mct   <= MCT_W'(1);
              end else begin
                r_state <= S_IDLE;
                r_mct   <= '0;
              end
            end
          end
        end
        S_HOLD: begin
          if (!i_stall) r_state <= r_hold_rupt ? S_RUPT : S_RUN;
        end
        S_RUPT: begin
          if (w_stall_now) begin
            r_state     <= S_HOLD;
            r_hold_rupt <= 1'b1;
          end else if (w_wrap) begin
            r_state <= S_IDLE;
            r_mct   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tp          = w_tp;
  assign o_mct         = r_mct;
  assign o_rd_en       = (r_state != S_IDLE) && (w_tp == TP_W'(RD_TP));
  assign o_wr_en       = (r_state != S_IDLE) && (w_tp == TP_W'(WR_TP));
  assign o_sub_done    = (r_state == S_RUN) && w_wrap && w_last_mct;
  assign o_busy        = (r_state != S_IDLE);
  assign o_in_rupt     = (r_state == S_RUPT) || ((r_state == S_HOLD) && r_hold_rupt);
  assign o_int_ack     = (r_state == S_RUPT) && w_wrap;
  assign o_extend_flag = r_extend_flag;

endmodule
